// File: rtl/pc_fetch_gen.sv
// Fetch PC generator for the GeMIPS IF stage: issues fetch requests over valid/ready,
// applies exception/branch redirects by priority, and tags each request with an epoch bit.
module pc_fetch_gen #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int          INC          = 4,
  parameter int          ALIGN_BITS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              exc_flag_i,
  input  logic [ADDR_W-1:0] exc_addr_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              req_ready_i,
  output logic              req_epoch_o,
  output logic [ADDR_W-1:0] pc_plus_inc_o,
  output logic              addr_err_o,
  output logic [ADDR_W-1:0] bad_addr_o
);

  localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              epoch_q, epoch_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

  logic fire;
  logic exc_mis, br_mis;
  logic exc_ok, br_ok;
  logic exc_err, br_err;

  assign req_valid_o   = valid_q & ~stall_i;
  assign req_addr_o    = pc_q;
  assign req_epoch_o   = epoch_q;
  assign pc_plus_inc_o = pc_q + INC_V;
  assign addr_err_o    = addr_err_q;
  assign bad_addr_o    = bad_addr_q;

  assign fire    = req_valid_o & req_ready_i;
  assign exc_mis = |(exc_addr_i & ALIGN_MASK);
  assign br_mis  = |(branch_addr_i & ALIGN_MASK);
  assign exc_ok  = exc_flag_i & ~exc_mis;
  assign br_ok   = branch_flag_i & ~br_mis;
  // A rejected exception masks the branch error so only one target is reported.
  assign exc_err = exc_flag_i & exc_mis;
  assign br_err  = branch_flag_i & br_mis & ~exc_flag_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    pc_d        = pc_q;
    valid_d     = valid_q;
    epoch_d     = epoch_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    addr_err_d  = 1'b0;
    bad_addr_d  = bad_addr_q;

    if (exc_err) begin
      addr_err_d = 1'b1;
      bad_addr_d = exc_addr_i;
    end else if (br_err) begin
      addr_err_d = 1'b1;
      bad_addr_d = branch_addr_i;
    end

    if (exc_ok) begin
      pc_d     = exc_addr_i;
      epoch_d  = ~epoch_q;
      pend_v_d = 1'b0;
      valid_d  = 1'b1;
    end else if (stall_i) begin
      if (br_ok) begin
        pend_v_d    = 1'b1;
        pend_addr_d = branch_addr_i;
      end
    end else begin
      valid_d = 1'b1;
      if (br_ok) begin
        pc_d     = branch_addr_i;
        epoch_d  = ~epoch_q;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        pc_d     = pend_addr_q;
        epoch_d  = ~epoch_q;
        pend_v_d = 1'b0;
      end else if (fire) begin
        pc_d = pc_q + INC_V;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      epoch_q    <= 1'b0;
      pend_v_q   <= 1'b0;
      addr_err_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      epoch_q    <= epoch_d;
      pend_v_q   <= pend_v_d;
      addr_err_q <= addr_err_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  // NOTE: the pending target is payload qualified by pend_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed test-plan scenarios plus randomized
// traffic compared against a behavioural model; a 16-bit instance covers wrap and reset.
module tb_pc_fetch_gen;

  localparam logic [31:0] RV_A = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, stall, br, exc, ready;
  logic [31:0] br_addr, exc_addr;
  logic        req_valid, req_epoch, addr_err;
  logic [31:0] req_addr, pc_plus_inc, bad_addr;

  pc_fetch_gen #(.ADDR_W(32), .RESET_VECTOR(RV_A), .INC(4), .ALIGN_BITS(2)) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall),
    .branch_flag_i(br), .branch_addr_i(br_addr),
    .exc_flag_i(exc), .exc_addr_i(exc_addr),
    .req_valid_o(req_valid), .req_addr_o(req_addr), .req_ready_i(ready),
    .req_epoch_o(req_epoch), .pc_plus_inc_o(pc_plus_inc),
    .addr_err_o(addr_err), .bad_addr_o(bad_addr)
  );

  // 16-bit instance; reset vector truncates to 16'hFFF0
  logic        b_rst, b_stall, b_br, b_ready;
  logic [15:0] b_br_addr, b_exc_addr;
  logic        b_req_valid, b_req_epoch, b_addr_err;
  logic [15:0] b_req_addr, b_pc_plus_inc, b_bad_addr;

  pc_fetch_gen #(.ADDR_W(16), .RESET_VECTOR(32'h0001_FFF0), .INC(4), .ALIGN_BITS(2)) dut_b (
    .clk(clk), .rst(b_rst), .stall_i(b_stall),
    .branch_flag_i(b_br), .branch_addr_i(b_br_addr),
    .exc_flag_i(1'b0), .exc_addr_i(b_exc_addr),
    .req_valid_o(b_req_valid), .req_addr_o(b_req_addr), .req_ready_i(b_ready),
    .req_epoch_o(b_req_epoch), .pc_plus_inc_o(b_pc_plus_inc),
    .addr_err_o(b_addr_err), .bad_addr_o(b_bad_addr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model of the 32-bit instance
  longint unsigned m_pc;
  bit              m_valid, m_epoch, m_err;
  logic [31:0]     m_bad;
  logic [31:0]     m_pend_q[$];

  function automatic bit aligned(input logic [31:0] a);
    return (a % 4) == 0;
  endfunction

  task automatic model_update();
    bit fire;
    if (rst) begin
      m_pc = RV_A; m_valid = 0; m_epoch = 0; m_err = 0; m_bad = '0;
      m_pend_q.delete();
      return;
    end
    fire  = m_valid && !stall && ready;
    m_err = 0;
    if (exc) begin
      if (aligned(exc_addr)) begin
        m_pc = exc_addr; m_epoch = !m_epoch; m_valid = 1;
        m_pend_q.delete();
        return;
      end
      m_err = 1; m_bad = exc_addr;
    end
    if (stall) begin
      if (br) begin
        if (aligned(br_addr)) m_pend_q = {br_addr};
        else if (!m_err) begin m_err = 1; m_bad = br_addr; end
      end
      return;
    end
    m_valid = 1;
    if (br) begin
      if (aligned(br_addr)) begin
        m_pc = br_addr; m_epoch = !m_epoch;
        m_pend_q.delete();
        return;
      end
      if (!m_err) begin m_err = 1; m_bad = br_addr; end
    end
    if (m_pend_q.size() != 0) begin
      m_pc = m_pend_q.pop_front(); m_epoch = !m_epoch;
      return;
    end
    if (fire) m_pc = (m_pc + 4) % 64'h1_0000_0000;
  endtask

  task automatic check_all();
    check("req_valid",   {31'd0, req_valid}, {31'd0, m_valid && !stall});
    check("req_addr",    req_addr, m_pc[31:0]);
    check("req_epoch",   {31'd0, req_epoch}, {31'd0, m_epoch});
    check("pc_plus_inc", pc_plus_inc, 32'((m_pc + 4) % 64'h1_0000_0000));
    check("addr_err",    {31'd0, addr_err}, {31'd0, m_err});
    check("bad_addr",    bad_addr, m_bad);
  endtask

  // Advance one clock with the current inputs, update the model, compare, drop pulses.
  task automatic step();
    @(posedge clk); #1;
    model_update();
    check_all();
    br = 1'b0; exc = 1'b0;
  endtask

  task automatic step_b();
    @(posedge clk); #1;
    b_br = 1'b0;
  endtask

  initial begin
    rst = 1; stall = 0; br = 0; exc = 0; ready = 0; br_addr = '0; exc_addr = '0;
    b_rst = 1; b_stall = 0; b_br = 0; b_ready = 0; b_br_addr = '0; b_exc_addr = '0;

    // Reset state
    step();
    check("rst_valid", {31'd0, req_valid}, 32'd0);
    check("rst_addr",  req_addr, 32'h8000_0000);

    // Sequential fetch with ready held high
    rst = 0; ready = 1;
    step(); check("seq1", req_addr, 32'h8000_0000);
    check("seq1_valid", {31'd0, req_valid}, 32'd1);
    step(); check("seq2", req_addr, 32'h8000_0004);
    step(); check("seq3", req_addr, 32'h8000_0008);
    check("seq_epoch", {31'd0, req_epoch}, 32'd0);
    step(); step(); check("at_0010", req_addr, 32'h8000_0010);

    // Back-pressure: address and valid stable
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_addr", req_addr, 32'h8000_0010);
      check("bp_valid", {31'd0, req_valid}, 32'd1);
    end
    ready = 1;
    step(); check("bp_release", req_addr, 32'h8000_0014);

    // Branch latched during a stall, applied on release
    stall = 1;
    step(); check("stall_valid", {31'd0, req_valid}, 32'd0);
    br = 1; br_addr = 32'h8000_0100;
    step(); check("stall_hold", req_addr, 32'h8000_0014);
    step(); step(); check("stall_hold2", req_addr, 32'h8000_0014);
    stall = 0;
    step(); check("pend_target", req_addr, 32'h8000_0100);
    check("pend_epoch", {31'd0, req_epoch}, 32'd1);

    // Exception beats branch and stall, clears pending
    stall = 1; exc = 1; exc_addr = 32'h8000_0180; br = 1; br_addr = 32'h8000_0200;
    step(); check("exc_target", req_addr, 32'h8000_0180);
    check("exc_epoch", {31'd0, req_epoch}, 32'd0);
    stall = 0;
    step(); check("exc_no_pend", req_addr, 32'h8000_0184);

    // Misaligned branch rejected
    br = 1; br_addr = 32'h8000_0102;
    step(); check("mis_err", {31'd0, addr_err}, 32'd1);
    check("mis_bad", bad_addr, 32'h8000_0102);
    check("mis_seq", req_addr, 32'h8000_0188);
    check("mis_epoch", {31'd0, req_epoch}, 32'd0);
    step(); check("mis_pulse", {31'd0, addr_err}, 32'd0);
    check("mis_bad_hold", bad_addr, 32'h8000_0102);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(99) < 2);
      stall = ($urandom_range(99) < 25);
      ready = ($urandom_range(99) < 70);
      br    = ($urandom_range(99) < 15);
      exc   = ($urandom_range(99) < 6);
      br_addr  = $urandom;
      exc_addr = $urandom;
      if ($urandom_range(99) < 75) br_addr[1:0]  = 2'b00;
      if ($urandom_range(99) < 80) exc_addr[1:0] = 2'b00;
      step();
    end
    rst = 0; stall = 0;

    // 16-bit instance: truncated reset vector, wrap, reset mid-stall
    b_rst = 1;
    step_b(); check("b_rst_addr", {16'd0, b_req_addr}, 32'h0000_FFF0);
    b_rst = 0; b_ready = 1;
    step_b(); check("b_first", {16'd0, b_req_addr}, 32'h0000_FFF0);
    step_b(); step_b(); step_b();
    check("b_fffc", {16'd0, b_req_addr}, 32'h0000_FFFC);
    check("b_inc_wrap", {16'd0, b_pc_plus_inc}, 32'h0000_0000);
    step_b(); check("b_wrap", {16'd0, b_req_addr}, 32'h0000_0000);
    b_stall = 1; b_br = 1; b_br_addr = 16'h0040;
    step_b(); check("b_stall_hold", {16'd0, b_req_addr}, 32'h0000_0000);
    b_rst = 1;
    step_b(); check("b_rst_mid", {16'd0, b_req_addr}, 32'h0000_FFF0);
    check("b_rst_valid", {31'd0, b_req_valid}, 32'd0);
    b_rst = 0; b_stall = 0;
    step_b(); check("b_no_pend", {16'd0, b_req_addr}, 32'h0000_FFF0);
    check("b_no_pend_epoch", {31'd0, b_req_epoch}, 32'd0);
    step_b(); check("b_after", {16'd0, b_req_addr}, 32'h0000_FFF4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
